// File: rtl/pc_jump_ctrl.sv
// Fetch-side PC generator and redirect controller: sequential PC advance, execute-stage
// redirects with a multi-cycle pipeline flush, a saturating redirect counter and a misalign trap.
module pc_jump_ctrl #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR   = '0,
  parameter int unsigned           PC_STEP      = 4,
  parameter int unsigned           FLUSH_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  jump_enable_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  hold_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  inst_valid_o,
  output logic                  flush_o,
  output logic                  misalign_o,
  output logic [15:0]           jump_count_o
);

  localparam int unsigned     CNT_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic            FLUSH_MULTI = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_FLUSH,
    ST_TRAP
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [CNT_W-1:0]      fcnt_q;
  logic [15:0]           jcnt_q;

  logic                  aligned;
  logic                  take;
  logic                  bad;
  logic [ADDR_WIDTH-1:0] pc_seq_d;
  logic [15:0]           jcnt_d;

  assign aligned  = (jump_addr_i[1:0] == 2'b00);
  assign take     = (state_q == ST_RUN) && jump_enable_i && aligned;
  assign bad      = (state_q == ST_RUN) && jump_enable_i && !aligned;
  assign pc_seq_d = pc_q + ADDR_WIDTH'(PC_STEP);
  assign jcnt_d   = (jcnt_q == 16'hFFFF) ? jcnt_q : jcnt_q + 16'd1;

  // NOTE: all state below is written with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_ADDR;
      fcnt_q  <= '0;
      jcnt_q  <= '0;
    end else begin
      case (state_q)
        ST_BOOT: state_q <= ST_RUN;
        ST_RUN: begin
          if (bad) begin
            state_q <= ST_TRAP;
          end else if (take) begin
            pc_q   <= jump_addr_i;
            jcnt_q <= jcnt_d;
            if (FLUSH_MULTI) begin
              fcnt_q  <= FLUSH_INIT;
              state_q <= ST_FLUSH;
            end
          end else if (!hold_i) begin
            pc_q <= pc_seq_d;
          end
        end
        // Jumps seen here come from wrong-path instructions and are dropped.
        ST_FLUSH: begin
          if (!hold_i) begin
            pc_q   <= pc_seq_d;
            fcnt_q <= fcnt_q - CNT_W'(1);
            if (fcnt_q == CNT_W'(1)) state_q <= ST_RUN;
          end
        end
        ST_TRAP: state_q <= ST_TRAP;
        default: state_q <= ST_TRAP;
      endcase
    end
  end

  assign pc_o         = pc_q;
  assign inst_valid_o = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign misalign_o   = (state_q == ST_TRAP);
  assign flush_o      = take || (state_q == ST_FLUSH);
  assign jump_count_o = jcnt_q;

endmodule

// File: tb/tb_pc_jump_ctrl.sv
// Directed bench for pc_jump_ctrl: default build, wrapped reset address with 3-cycle flush,
// and a single-cycle-flush build driven into redirect-counter saturation.
module tb_pc_jump_ctrl;

  typedef struct {
    logic        je;
    logic [31:0] addr;
    logic        hold;
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        mis;
    logic [15:0] cnt;
  } vec_t;

  logic clk;
  logic rst_a, je_a, hold_a, valid_a, flush_a, mis_a;
  logic rst_b, je_b, hold_b, valid_b, flush_b, mis_b;
  logic rst_c, je_c, hold_c, valid_c, flush_c, mis_c;
  logic [31:0] addr_a, pc_a, addr_b, pc_b, addr_c, pc_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  int n_tests = 0;
  int n_fail  = 0;

  pc_jump_ctrl u_a (
    .clk_i(clk), .rst_i(rst_a), .jump_enable_i(je_a), .jump_addr_i(addr_a), .hold_i(hold_a),
    .pc_o(pc_a), .inst_valid_o(valid_a), .flush_o(flush_a), .misalign_o(mis_a),
    .jump_count_o(cnt_a)
  );

  pc_jump_ctrl #(.RESET_ADDR(32'hFFFF_FFF8), .FLUSH_CYCLES(3)) u_b (
    .clk_i(clk), .rst_i(rst_b), .jump_enable_i(je_b), .jump_addr_i(addr_b), .hold_i(hold_b),
    .pc_o(pc_b), .inst_valid_o(valid_b), .flush_o(flush_b), .misalign_o(mis_b),
    .jump_count_o(cnt_b)
  );

  pc_jump_ctrl #(.FLUSH_CYCLES(1)) u_c (
    .clk_i(clk), .rst_i(rst_c), .jump_enable_i(je_c), .jump_addr_i(addr_c), .hold_i(hold_c),
    .pc_o(pc_c), .inst_valid_o(valid_c), .flush_o(flush_c), .misalign_o(mis_c),
    .jump_count_o(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one vector, checks the cycle's outputs, then advances one edge.
  task automatic run_vec(input int inst, input int idx, input vec_t v);
    logic [31:0] pc;
    logic        valid, flush, mis;
    logic [15:0] cnt;
    string       tag;
    tag = (inst == 0) ? "A" : "B";
    if (inst == 0) begin
      je_a = v.je; addr_a = v.addr; hold_a = v.hold;
    end else begin
      je_b = v.je; addr_b = v.addr; hold_b = v.hold;
    end
    #1;
    if (inst == 0) begin
      pc = pc_a; valid = valid_a; flush = flush_a; mis = mis_a; cnt = cnt_a;
    end else begin
      pc = pc_b; valid = valid_b; flush = flush_b; mis = mis_b; cnt = cnt_b;
    end
    check($sformatf("%s[%0d].pc", tag, idx), pc, v.pc);
    check($sformatf("%s[%0d].valid", tag, idx), 32'(valid), 32'(v.valid));
    check($sformatf("%s[%0d].flush", tag, idx), 32'(flush), 32'(v.flush));
    check($sformatf("%s[%0d].misalign", tag, idx), 32'(mis), 32'(v.mis));
    check($sformatf("%s[%0d].count", tag, idx), 32'(cnt), 32'(v.cnt));
    @(posedge clk); #1;
  endtask

  vec_t va[16];
  vec_t vb[10];

  initial begin
    //          je    addr          hold  pc            valid flush mis   cnt
    va[0]  = '{1'b1, 32'h200,      1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd0};
    va[1]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'd0};
    va[2]  = '{1'b0, 32'h0,        1'b0, 32'h4,        1'b1, 1'b0, 1'b0, 16'd0};
    va[3]  = '{1'b0, 32'h0,        1'b0, 32'h8,        1'b1, 1'b0, 1'b0, 16'd0};
    va[4]  = '{1'b0, 32'h0,        1'b0, 32'hC,        1'b1, 1'b0, 1'b0, 16'd0};
    va[5]  = '{1'b1, 32'h100,      1'b0, 32'h10,       1'b1, 1'b1, 1'b0, 16'd0};
    va[6]  = '{1'b0, 32'h0,        1'b0, 32'h100,      1'b1, 1'b1, 1'b0, 16'd1};
    va[7]  = '{1'b0, 32'h0,        1'b0, 32'h104,      1'b1, 1'b0, 1'b0, 16'd1};
    va[8]  = '{1'b0, 32'h0,        1'b1, 32'h108,      1'b1, 1'b0, 1'b0, 16'd1};
    va[9]  = '{1'b1, 32'h40,       1'b1, 32'h108,      1'b1, 1'b1, 1'b0, 16'd1};
    va[10] = '{1'b0, 32'h0,        1'b1, 32'h40,       1'b1, 1'b1, 1'b0, 16'd2};
    va[11] = '{1'b1, 32'h300,      1'b1, 32'h40,       1'b1, 1'b1, 1'b0, 16'd2};
    va[12] = '{1'b0, 32'h0,        1'b0, 32'h40,       1'b1, 1'b1, 1'b0, 16'd2};
    va[13] = '{1'b0, 32'h0,        1'b0, 32'h44,       1'b1, 1'b0, 1'b0, 16'd2};
    va[14] = '{1'b1, 32'h102,      1'b0, 32'h48,       1'b1, 1'b0, 1'b0, 16'd2};
    va[15] = '{1'b1, 32'h200,      1'b0, 32'h48,       1'b0, 1'b0, 1'b1, 16'd2};

    vb[0]  = '{1'b1, 32'h40,       1'b0, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 16'd0};
    vb[1]  = '{1'b0, 32'h0,        1'b0, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0, 16'd0};
    vb[2]  = '{1'b0, 32'h0,        1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 16'd0};
    vb[3]  = '{1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 16'd0};
    vb[4]  = '{1'b1, 32'h20,       1'b0, 32'h4,         1'b1, 1'b1, 1'b0, 16'd0};
    vb[5]  = '{1'b1, 32'h60,       1'b0, 32'h20,        1'b1, 1'b1, 1'b0, 16'd1};
    vb[6]  = '{1'b0, 32'h0,        1'b1, 32'h24,        1'b1, 1'b1, 1'b0, 16'd1};
    vb[7]  = '{1'b0, 32'h0,        1'b0, 32'h24,        1'b1, 1'b1, 1'b0, 16'd1};
    vb[8]  = '{1'b0, 32'h0,        1'b0, 32'h28,        1'b1, 1'b0, 1'b0, 16'd1};
    vb[9]  = '{1'b0, 32'h0,        1'b0, 32'h2C,        1'b1, 1'b0, 1'b0, 16'd1};

    rst_a = 1'b1; je_a = 1'b1; addr_a = 32'h80; hold_a = 1'b0;
    rst_b = 1'b1; je_b = 1'b0; addr_b = 32'h0;  hold_b = 1'b0;
    rst_c = 1'b1; je_c = 1'b0; addr_c = 32'h0;  hold_c = 1'b0;

    fork
      begin : main_seq
        #1;
        check("A.reset.pc", pc_a, 32'h0);
        check("A.reset.flush", 32'(flush_a), 32'h0);
        @(posedge clk); #1;
        check("A.reset_held.valid", 32'(valid_a), 32'h0);
        rst_a = 1'b0;
        for (int i = 0; i < 16; i++) run_vec(0, i, va[i]);

        // Trap is sticky: jumps, steps and holds all leave pc frozen.
        for (int i = 0; i < 10; i++) begin
          je_a   = (i % 2 == 0);
          addr_a = 32'h80 + 32'(i * 2);
          hold_a = (i % 4 == 3);
          #1;
          check($sformatf("A.trap[%0d].pc", i), pc_a, 32'h48);
          check($sformatf("A.trap[%0d].valid", i), 32'(valid_a), 32'h0);
          check($sformatf("A.trap[%0d].flush", i), 32'(flush_a), 32'h0);
          check($sformatf("A.trap[%0d].misalign", i), 32'(mis_a), 32'h1);
          @(posedge clk); #1;
        end
        check("A.trap.count", 32'(cnt_a), 32'h2);

        rst_a = 1'b1;
        #1;
        check("A.rst_trap.pc", pc_a, 32'h0);
        check("A.rst_trap.misalign", 32'(mis_a), 32'h0);
        check("A.rst_trap.count", 32'(cnt_a), 32'h0);
        @(posedge clk); #1;
        rst_a = 1'b0; je_a = 1'b0; hold_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("A.rerun.pc", pc_a, 32'h4);
        je_a = 1'b1; addr_a = 32'h80;
        #1;
        check("A.rerun.flush_redirect", 32'(flush_a), 32'h1);
        @(posedge clk); #1;
        je_a = 1'b0;
        #1;
        check("A.midflush.pc", pc_a, 32'h80);
        check("A.midflush.flush", 32'(flush_a), 32'h1);
        #2 rst_a = 1'b1;
        #1;
        check("A.async_rst.pc", pc_a, 32'h0);
        check("A.async_rst.flush", 32'(flush_a), 32'h0);
        check("A.async_rst.valid", 32'(valid_a), 32'h0);
        check("A.async_rst.count", 32'(cnt_a), 32'h0);

        @(posedge clk); #1;
        rst_b = 1'b0;
        for (int i = 0; i < 10; i++) run_vec(1, i, vb[i]);
      end

      begin : sat_seq
        @(posedge clk); #1;
        rst_c = 1'b0;
        je_c   = 1'b1;
        addr_c = 32'h10;
        for (int i = 1; i <= 32'h10001; i++) begin
          @(posedge clk); #1;
          if (i == 1) begin
            check("C.boot_exit.pc", pc_c, 32'h0);
            check("C.boot_exit.count", 32'(cnt_c), 32'h0);
          end
          if (i == 2) begin
            check("C.single_flush.pc", pc_c, 32'h8);
            check("C.single_flush.flush", 32'(flush_c), 32'h1);
            check("C.single_flush.valid", 32'(valid_c), 32'h1);
          end
          if (i == 32'hFFFF)  check("C.count_FFFE", 32'(cnt_c), 32'hFFFE);
          if (i == 32'h10000) check("C.count_FFFF", 32'(cnt_c), 32'hFFFF);
          if (i == 32'h10001) check("C.count_sat", 32'(cnt_c), 32'hFFFF);
          addr_c = 32'(i * 8) & 32'h0000_FFFC;
        end
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
